// File: rtl/mem_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : mem_fifo_reader
//  Purpose  : Consumer-side read engine for memory_core running as a FIFO.
//             Tracks core occupancy from the observed write port and issues
//             ren_out while skid credit allows. It checks each returned word
//             in order against a shadow copy of the written data and forwards
//             the returned data to a valid/ready sink through a skid buffer.
//  Ports    : clk, reset (async, active-low), clk_en (global freeze),
//             flush (sync datapath clear), depth (configured FIFO depth),
//             wen_obs/wdata_obs (observed core write port),
//             ren_out (core ren_in), rdata_in/rvalid_in (core read return),
//             out_data/out_valid/out_ready (downstream sink),
//             occupancy (writes minus issued reads),
//             err_overflow/err_spurious/err_lost/err_mismatch/err_config
//             (sticky error flags, cleared only by reset).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_fifo_reader #(
  parameter int DATA_WIDTH   = 16,
  parameter int CNT_WIDTH    = 16,
  parameter int SHADOW_DEPTH = 16,
  parameter int SKID_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [CNT_WIDTH-1:0]  depth,
  input  logic                  wen_obs,
  input  logic [DATA_WIDTH-1:0] wdata_obs,
  output logic                  ren_out,
  input  logic [DATA_WIDTH-1:0] rdata_in,
  input  logic                  rvalid_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic                  err_overflow,
  output logic                  err_spurious,
  output logic                  err_lost,
  output logic                  err_mismatch,
  output logic                  err_config
);

  localparam int c_sh_aw = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;
  localparam int c_sh_n  = 1 << c_sh_aw;
  localparam int c_sk_aw = $clog2(SKID_DEPTH);
  localparam int c_sk_cw = $clog2(SKID_DEPTH + 1);

  localparam logic [c_sk_aw-1:0]   c_sk_last  = c_sk_aw'(SKID_DEPTH - 1);
  localparam logic [c_sk_cw:0]     c_sk_lim   = (c_sk_cw + 1)'(SKID_DEPTH);
  localparam logic [CNT_WIDTH-1:0] c_depth_mx = CNT_WIDTH'(SHADOW_DEPTH);

  // Occupancy / return tracking
  logic [CNT_WIDTH-1:0]  r_occ;
  logic                  r_inflight;
  logic                  r_cfg_done;

  // Shadow queue of accepted writes. The head is moved into r_expect when the
  // read is issued, so the array never has to hold more than depth entries
  // even while a read is in flight.
  logic [DATA_WIDTH-1:0] r_sh_mem [0:c_sh_n-1];
  logic [c_sh_aw-1:0]    r_sh_wr;
  logic [c_sh_aw-1:0]    r_sh_rd;
  logic [DATA_WIDTH-1:0] r_expect;

  // Output skid buffer
  logic [DATA_WIDTH-1:0] r_sk_mem [0:SKID_DEPTH-1];
  logic [c_sk_aw-1:0]    r_sk_wr;
  logic [c_sk_aw-1:0]    r_sk_rd;
  logic [c_sk_cw-1:0]    r_sk_cnt;

  // Sticky errors
  logic r_err_overflow;
  logic r_err_spurious;
  logic r_err_lost;
  logic r_err_mismatch;
  logic r_err_config;

  logic                  w_pop;
  logic [c_sk_cw:0]      w_credit;
  logic                  w_room;
  logic                  w_wr_acc;
  logic                  w_overflow;
  logic                  w_ret_ok;
  logic                  w_lost;
  logic                  w_spur;
  logic                  w_mismatch;
  logic                  w_depth_bad;

  assign out_valid = (r_sk_cnt != '0);
  // Gated so the data port reads 0 whenever the skid is empty (and in reset).
  assign out_data  = out_valid ? r_sk_mem[r_sk_rd] : '0;
  assign w_pop     = out_valid & out_ready;

  // Skid slots already used or promised to the in-flight read, less the one
  // leaving this cycle. pop implies r_sk_cnt>0, so this never underflows.
  assign w_credit = {1'b0, r_sk_cnt}
                  + {{c_sk_cw{1'b0}}, r_inflight}
                  - {{c_sk_cw{1'b0}}, w_pop};

  assign ren_out = clk_en & ~flush & ~r_err_config & (r_occ != '0) &
                   (w_credit < c_sk_lim);

  // A read issued this cycle frees a slot, so a write at full depth is still
  // accepted when it coincides with ren_out.
  assign w_room      = (r_occ < depth);
  assign w_wr_acc    = wen_obs & (w_room | ren_out);
  assign w_overflow  = wen_obs & ~w_room & ~ren_out;

  assign w_ret_ok    = r_inflight & rvalid_in;
  assign w_lost      = r_inflight & ~rvalid_in;
  assign w_spur      = ~r_inflight & rvalid_in;
  assign w_mismatch  = w_ret_ok & (rdata_in != r_expect);

  assign w_depth_bad = (depth == '0) | (depth > c_depth_mx);

  assign occupancy    = r_occ;
  assign err_overflow = r_err_overflow;
  assign err_spurious = r_err_spurious;
  assign err_lost     = r_err_lost;
  assign err_mismatch = r_err_mismatch;
  assign err_config   = r_err_config;

  // Storage arrays carry no reset; their contents are only observed through
  // pointers and counts that are reset.
  always_ff @(posedge clk) begin
    if (clk_en && !flush) begin
      if (w_wr_acc) begin
        r_sh_mem[r_sh_wr] <= wdata_obs;
      end
      if (w_ret_ok) begin
        r_sk_mem[r_sk_wr] <= rdata_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ          <= '0;
      r_inflight     <= 1'b0;
      r_cfg_done     <= 1'b0;
      r_sh_wr        <= '0;
      r_sh_rd        <= '0;
      r_expect       <= '0;
      r_sk_wr        <= '0;
      r_sk_rd        <= '0;
      r_sk_cnt       <= '0;
      r_err_overflow <= 1'b0;
      r_err_spurious <= 1'b0;
      r_err_lost     <= 1'b0;
      r_err_mismatch <= 1'b0;
      r_err_config   <= 1'b0;
    end else if (clk_en) begin
      // Depth is static after reset, so one check on the first live cycle.
      if (!r_cfg_done) begin
        r_cfg_done <= 1'b1;
        if (w_depth_bad) begin
          r_err_config <= 1'b1;
        end
      end

      if (flush) begin
        r_occ      <= '0;
        r_inflight <= 1'b0;
        r_sh_wr    <= '0;
        r_sh_rd    <= '0;
        r_sk_wr    <= '0;
        r_sk_rd    <= '0;
        r_sk_cnt   <= '0;
      end else begin
        r_occ      <= r_occ + {{(CNT_WIDTH-1){1'b0}}, w_wr_acc}
                            - {{(CNT_WIDTH-1){1'b0}}, ren_out};
        r_inflight <= ren_out;

        if (w_wr_acc) begin
          r_sh_wr <= r_sh_wr + c_sh_aw'(1);
        end
        if (ren_out) begin
          r_sh_rd  <= r_sh_rd + c_sh_aw'(1);
          r_expect <= r_sh_mem[r_sh_rd];
        end

        if (w_ret_ok) begin
          r_sk_wr <= (r_sk_wr == c_sk_last) ? '0 : r_sk_wr + c_sk_aw'(1);
        end
        if (w_pop) begin
          r_sk_rd <= (r_sk_rd == c_sk_last) ? '0 : r_sk_rd + c_sk_aw'(1);
        end
        case ({w_ret_ok, w_pop})
          2'b10:   r_sk_cnt <= r_sk_cnt + c_sk_cw'(1);
          2'b01:   r_sk_cnt <= r_sk_cnt - c_sk_cw'(1);
          default: r_sk_cnt <= r_sk_cnt;
        endcase

        if (w_overflow) r_err_overflow <= 1'b1;
        if (w_spur)     r_err_spurious <= 1'b1;
        if (w_lost)     r_err_lost     <= 1'b1;
        if (w_mismatch) r_err_mismatch <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_fifo_reader.md
Name: mem_fifo_reader

Overview:
- Consumer-side engine for memory_core in FIFO mode (mode=1, tile_en=1, chaining off).
- Watches the write port (wen/data) driven by the AQED front end and tracks FIFO occupancy against the configured depth.
- Issues ren_in to the core and captures data_out/valid_out, which return one cycle after the read request.
- Checks returned words in order against a shadow queue, then forwards them to a downstream valid/ready sink through a small skid buffer.

Parameters:
- DATA_WIDTH, 16, word width of the core data ports.
- CNT_WIDTH, 16, width of depth and occupancy.
- SHADOW_DEPTH, 16, shadow-queue entries (power of 2); largest legal depth.
- SKID_DEPTH, 2, output skid-buffer entries (>=2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- clk_en  in  1  global enable; low freezes all state.
- flush  in  1  synchronous clear of datapath state.
- depth  in  CNT_WIDTH  configured FIFO depth; static after reset.
- wen_obs  in  1  write strobe seen at core wen_in.
- wdata_obs  in  DATA_WIDTH  data seen at core data_in.
- ren_out  out  1  read request to core ren_in.
- rdata_in  in  DATA_WIDTH  core data_out.
- rvalid_in  in  1  core valid_out.
- out_data  out  DATA_WIDTH  skid head data.
- out_valid  out  1  skid non-empty.
- out_ready  in  1  downstream accept.
- occupancy  out  CNT_WIDTH  writes minus issued reads.
- err_overflow  out  1  sticky.
- err_spurious  out  1  sticky.
- err_lost  out  1  sticky.
- err_mismatch  out  1  sticky.
- err_config  out  1  sticky.

Behaviour:
Reset (reset=0, async):
- occupancy, inflight, shadow pointers and skid_count all 0.
- All outputs 0; all err_* cleared.
- err_* are cleared only by reset.

Gating:
- clk_en=0: no register updates. ren_out=0. wen_obs and rvalid_in are ignored.
- flush=1 (with clk_en=1): next cycle occupancy=0, inflight=0, shadow empty, skid empty. ren_out=0 during the flush cycle. err_* retained.

Config:
- err_config sets on the first enabled cycle after reset when depth==0 or depth>SHADOW_DEPTH.
- While err_config=1, ren_out is held 0.

Write tracking:
- A write is accepted when wen_obs=1 and (occupancy<depth or ren_out=1 this cycle).
- Accepted write: push wdata_obs into the shadow tail.
- Write while occupancy==depth and ren_out=0: err_overflow<=1; write dropped (occupancy and shadow unchanged).

Read issue (combinational):
- pop = out_valid & out_ready.
- ren_out = clk_en & ~flush & ~err_config & (occupancy>0) & (skid_count + inflight - pop < SKID_DEPTH).
- occupancy next = occupancy + accepted_write - ren_out. Simultaneous write and read leaves it unchanged.

Return path:
- inflight (1 bit) <= ren_out. Data is expected exactly one cycle after ren_out.
- inflight=1, rvalid_in=1:
  - compare rdata_in with the shadow head; inequality sets err_mismatch;
  - pop the shadow head;
  - push rdata_in into the skid (forwarded even on mismatch).
- inflight=1, rvalid_in=0: err_lost<=1; shadow head popped; nothing pushed.
- inflight=0, rvalid_in=1: err_spurious<=1; data dropped.

Skid:
- In-order FIFO. out_valid = skid_count>0; out_data = head.
- Push and pop in the same cycle is legal; skid_count is unchanged.
- The credit rule guarantees no skid overflow.

Throughput:
- With out_ready held high and occupancy>0: one read per cycle.
- First out_valid appears 2 cycles after the first ren_out.

Test Plan:
1. depth=4; write A,B,C,D on consecutive cycles, out_ready=1, model returns data 1 cycle after ren -> out_data sequence A,B,C,D on 4 consecutive cycles; occupancy peaks at 1 (reads track writes); all err_*=0.
2. depth=2, ren blocked (out_ready=0, skid full); write 3 words -> occupancy=2, err_overflow=1 on 3rd write, third word never appears on out_data.
3. depth=4, 4 words stored, out_ready=0 -> exactly 2 ren_out pulses, out_valid=1 with first word held; raise out_ready -> remaining 2 words drain in order, occupancy returns to 0.
4. Model returns 0xBEEF where 0x1234 was written -> err_mismatch=1, out_data=0xBEEF still delivered; a rvalid_in pulse with no prior ren_out -> err_spurious=1.
5. Mid-stream (occupancy=3, inflight=1) assert flush one cycle -> next cycle occupancy=0, out_valid=0, ren_out=0; err_* unchanged. Then depth=20 at reset release -> err_config=1, ren_out stays 0. Async reset low mid-transfer -> all outputs 0 immediately.
